// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg
//   Shared definitions for the decode/issue stage: FSM state codes, opcode
//   encodings, instruction class codes, the r_zero register index and the
//   combinational instruction decoder used by the issue logic.
package decode_issue_pkg;

  // Issue-stage FSM states.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  // Instruction classes.
  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_R   = 3'd1,
    CLS_LI  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4
  } class_e;

  // Opcodes 0x0..OP_R_LAST are all R-type; every unlisted opcode is a NOP.
  localparam logic [3:0] OP_R_LAST = 4'h7;
  localparam logic [3:0] OP_LI     = 4'hC;
  localparam logic [3:0] OP_ST     = 4'hD;
  localparam logic [3:0] OP_BR     = 4'hE;

  // Hard-wired zero register: never written, never tracked as pending.
  localparam logic [3:0] R_ZERO = 4'h0;

  // Decoded view of a held instruction.
  typedef struct packed {
    logic        use_rs;    // rs is a read source
    logic        use_src2;  // second read port is a real source
    logic [3:0]  src2;      // second read index (rt, or rd for stores)
    logic        we;        // instruction writes rd
    logic [15:0] imm;       // sign-extended immediate
  } decode_t;

  function automatic class_e classify(input logic [3:0] opcode);
    class_e cls;
    if (opcode <= OP_R_LAST)   cls = CLS_R;
    else if (opcode == OP_LI)  cls = CLS_LI;
    else if (opcode == OP_ST)  cls = CLS_ST;
    else if (opcode == OP_BR)  cls = CLS_BR;
    else                       cls = CLS_NOP;
    return cls;
  endfunction

  // Stores read the data register through the second port, so src2 becomes
  // rd for them; every other class keeps rt there.
  function automatic decode_t decode_instr(input logic [15:0] instr);
    decode_t    d;
    logic [3:0] rd;
    rd         = instr[11:8];
    d.use_rs   = 1'b0;
    d.use_src2 = 1'b0;
    d.src2     = instr[3:0];
    d.we       = 1'b0;
    d.imm      = {{12{instr[3]}}, instr[3:0]};
    case (classify(instr[15:12]))
      CLS_R: begin
        d.use_rs   = 1'b1;
        d.use_src2 = 1'b1;
        d.we       = (rd != R_ZERO);
      end
      CLS_LI: begin
        d.we  = (rd != R_ZERO);
        d.imm = {{8{instr[7]}}, instr[7:0]};
      end
      CLS_ST: begin
        d.use_rs   = 1'b1;
        d.use_src2 = 1'b1;
        d.src2     = rd;
      end
      CLS_BR: begin
        d.use_rs   = 1'b1;
        d.use_src2 = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// scoreboard
//   Pending-write tracker: one busy bit per architectural register.
//   Ports:
//     clk, rst            clock and synchronous active-high reset
//     set_en, set_idx     mark a register as having a write in flight
//     clr_en, clr_idx     writeback commit clears the register's bit
//     busy[15:0]          registered pending-write vector
module scoreboard
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [3:0]  set_idx,
  input  logic        clr_en,
  input  logic [3:0]  clr_idx,
  output logic [15:0] busy
);

  logic [15:0] busy_q, busy_d;
  logic [15:0] set_mask, clr_mask;

  // The zero register is filtered from both paths so its bit stays clear.
  // The set is applied after the clear, so a same-edge set and clear of one
  // register leaves it pending (the new write is still outstanding).
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_idx != R_ZERO)) set_mask[set_idx] = 1'b1;
    if (clr_en && (clr_idx != R_ZERO)) clr_mask[clr_idx] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/decode_issue.sv
// decode_issue
//   Single-entry decode/issue stage with scoreboard-based hazard stalling.
//   An accepted instruction is held, its sources go to the register file,
//   and it is issued downstream once none of its sources or its destination
//   have a write in flight.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     instr_in, instr_valid,
//     instr_ready                 upstream instruction handshake
//     read_reg1, read_reg2        register-file read indices
//     issue_valid, issue_ready    downstream handshake
//     issue_opcode, issue_rd,
//     issue_imm, issue_we         decoded fields of the issued instruction
//     wb_valid, wb_reg            writeback commit notification
//     stall_count                 saturating count of hazard-stalled cycles
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  read_reg1,
  output logic [3:0]  read_reg2,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  issue_opcode,
  output logic [3:0]  issue_rd,
  output logic [15:0] issue_imm,
  output logic        issue_we,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  output logic [15:0] stall_count
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        issue_valid_q, issue_valid_d;
  logic [15:0] stall_q, stall_d;

  decode_t     dec;
  logic [15:0] busy;
  logic        hazard;
  logic        up_hs;
  logic        dn_hs;

  assign dec = decode_instr(instr_q);

  // Only the registered busy vector is consulted; a writeback landing this
  // cycle is seen one cycle later. WAW counts as a hazard too.
  assign hazard = (dec.use_rs   & busy[instr_q[7:4]])
                | (dec.use_src2 & busy[dec.src2])
                | (dec.we       & busy[instr_q[11:8]]);

  // In ISSUE a new instruction can only enter on the same edge the current
  // one leaves, which keeps the single holding register sufficient.
  assign instr_ready = (state_q == EMPTY) | ((state_q == ISSUE) & issue_ready);
  assign up_hs       = instr_valid & instr_ready;
  assign dn_hs       = issue_valid_q & issue_ready;

  scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (dn_hs & dec.we),
    .set_idx (instr_q[11:8]),
    .clr_en  (wb_valid),
    .clr_idx (wb_reg),
    .busy    (busy)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    stall_d = stall_q;
    case (state_q)
      EMPTY: begin
        if (up_hs) begin
          state_d = HOLD;
          instr_d = instr_in;
        end
      end
      HOLD: begin
        if (!hazard) begin
          state_d = ISSUE;
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
      end
      ISSUE: begin
        if (dn_hs) begin
          if (up_hs) begin
            state_d = HOLD;
            instr_d = instr_in;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    issue_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      instr_q       <= '0;
      issue_valid_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      issue_valid_q <= issue_valid_d;
      stall_q       <= stall_d;
    end
  end

  // Everything below derives from the holding register, so the outputs stay
  // stable for as long as the instruction is held.
  assign read_reg1    = instr_q[7:4];
  assign read_reg2    = dec.src2;
  assign issue_valid  = issue_valid_q;
  assign issue_opcode = instr_q[15:12];
  assign issue_rd     = instr_q[11:8];
  assign issue_imm    = dec.imm;
  assign issue_we     = dec.we;
  assign stall_count  = stall_q;

endmodule
